// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared size encodings, FSM states and lane helpers for the data memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE   = 2'd0,
        SZ_HALF   = 2'd1,
        SZ_WORD   = 2'd2,
        SZ_DOUBLE = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [7:0] size_byte_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            SZ_BYTE:   mask = 8'h01;
            SZ_HALF:   mask = 8'h03;
            SZ_WORD:   mask = 8'h0F;
            default:   mask = 8'hFF;
        endcase
        return mask;
    endfunction

    function automatic logic [63:0] lanes_to_bits(input logic [7:0] lanes);
        logic [63:0] bits;
        for (int i = 0; i < 8; i++) begin
            bits[i*8 +: 8] = {8{lanes[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response channels between core and responder
interface data_mem_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/mem_storage.sv
// rtl/mem_storage.sv - doubleword register array with byte-enabled synchronous write and async read
module mem_storage #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [7:0]    wbe,
    input  logic [AW-1:0] addr,
    input  logic [63:0]   wdata,
    output logic [63:0]   rdata
);
    logic [63:0] mem [DEPTH];

    // Contents intentionally survive reset, so the array has no reset term.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                if (wbe[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data memory responder with programmable wait states
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          resetN,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                cap_write_q;
    logic [1:0]          cap_size_q;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic [DATA_W-1:0]   cap_wdata_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_error_q;

    logic                accept;
    logic                access_en;
    logic                acc_write;
    logic [1:0]          acc_size;
    logic [ADDR_W-1:0]   acc_addr;
    logic [DATA_W-1:0]   acc_wdata;
    logic                acc_error;
    logic [5:0]          lane_shift;
    logic [7:0]          wbe;
    logic                mem_we;
    logic [63:0]         mem_rdata;
    logic [63:0]         load_data;

    assign accept = (state_q == IDLE) && bus.req_valid;

    // With zero wait states the access happens on the accept edge itself,
    // so the operands come straight from the request rather than the capture.
    assign acc_write = accept ? bus.req_write : cap_write_q;
    assign acc_size  = accept ? bus.req_size  : cap_size_q;
    assign acc_addr  = accept ? bus.req_addr  : cap_addr_q;
    assign acc_wdata = accept ? bus.req_wdata : cap_wdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        access_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (LATENCY == 0) begin
                        state_d   = RESP;
                        access_en = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    access_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign acc_error = ((acc_addr[2:0] & 3'((4'd1 << acc_size) - 4'd1)) != 3'd0)
                     || ((acc_addr >> (AW + 3)) != '0);
    assign lane_shift = {acc_addr[2:0], 3'b000};
    assign wbe        = size_byte_mask(acc_size) << acc_addr[2:0];
    // resetN gates the write so a request abandoned by reset never lands.
    assign mem_we     = access_en && acc_write && !acc_error && resetN;
    assign load_data  = (mem_rdata >> lane_shift) & lanes_to_bits(size_byte_mask(acc_size));

    mem_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .wbe   (wbe),
        .addr  (acc_addr[AW+2:3]),
        .wdata (acc_wdata << lane_shift),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cap_write_q <= 1'b0;
            cap_size_q  <= 2'd0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                cap_write_q <= bus.req_write;
                cap_size_q  <= bus.req_size;
                cap_addr_q  <= bus.req_addr;
                cap_wdata_q <= bus.req_wdata;
            end
            if (access_en) begin
                rsp_error_q <= acc_error;
                rsp_rdata_q <= (acc_write || acc_error) ? '0 : load_data;
            end else if (state_q == RESP && bus.rsp_ready) begin
                rsp_error_q <= 1'b0;
                rsp_rdata_q <= '0;
            end
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

endmodule
